// File: rtl/a_plus_b_join_skid_pkg.sv
// Shared constants and helpers for the A+B join adder.
// The package has no ports.
package a_plus_b_join_skid_pkg;

  // Width of the delivered-result counter.
  localparam int unsigned COUNT_W = 16;

  // Modulo-2^COUNT_W increment.
  function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] c);
    return c + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/valid_ready_skid_buffer.sv
// Two-entry valid/ready output stage made of a main register and a skid register.
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_valid / in_ready / in_data   upstream stream; in_ready depends only on state and rst
//   out_valid / out_ready / out_data  downstream stream; out_data is always the main register
module valid_ready_skid_buffer #(
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              fire;
  logic              pop;

  // Ready and valid come from state only; rst forces the stream idle.
  assign in_ready  = (state != TWO) && !rst;
  assign out_valid = (state != EMPTY) && !rst;
  assign out_data  = rst ? '0 : main_q;

  assign fire = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy state machine with main/skid datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (fire && pop) begin
            main_q <= in_data;
          end else if (fire) begin
            skid_q <= in_data;
            state  <= TWO;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          // Full: no fire possible, the skid entry moves up on a pop.
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/a_plus_b_join_skid.sv
// Joins an A and a B operand stream, adds them without overflow and
// delivers the sum through a two-entry skid stage; counts delivered results.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   a_valid / a_ready / a_data       operand A stream
//   b_valid / b_ready / b_data       operand B stream
//   sum_valid / sum_ready / sum_data result stream, width+1 bits
//   sum_count                        results delivered, modulo 2^16
module a_plus_b_join_skid
  import a_plus_b_join_skid_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [width-1:0]   a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [width-1:0]   b_data,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [width:0]     sum_data,
  output logic [COUNT_W-1:0] sum_count
);

  localparam int unsigned SUM_W = width + 1;

  logic             in_ready;
  logic [SUM_W-1:0] sum;

  // Each side is ready only when its partner is valid, so both advance together.
  assign a_ready = b_valid && in_ready;
  assign b_ready = a_valid && in_ready;

  // Zero-extended add keeps the carry.
  assign sum = SUM_W'(a_data) + SUM_W'(b_data);

  valid_ready_skid_buffer #(
    .DATA_W (SUM_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_valid && b_valid),
    .in_ready  (in_ready),
    .in_data   (sum),
    .out_valid (sum_valid),
    .out_ready (sum_ready),
    .out_data  (sum_data)
  );

  // Delivered-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_count <= '0;
    end else if (sum_valid && sum_ready) begin
      sum_count <= count_next(sum_count);
    end
  end

endmodule

// File: doc/a_plus_b_join_skid.md
A_PLUS_B_JOIN_SKID -- requirements
Module: a_plus_b_join_skid

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: width, default 8, operand width in bits.
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: a_valid  input  1  operand A stream valid.
REQ-006 Port: a_ready  output  1  operand A stream ready.
REQ-007 Port: a_data  input  width  operand A.
REQ-008 Port: b_valid  input  1  operand B stream valid.
REQ-009 Port: b_ready  output  1  operand B stream ready.
REQ-010 Port: b_data  input  width  operand B.
REQ-011 Port: sum_valid  output  1  result stream valid.
REQ-012 Port: sum_ready  input  1  result stream ready.
REQ-013 Port: sum_data  output  width+1  result A+B.
REQ-014 Port: sum_count  output  16  count of results delivered (sum_valid & sum_ready).

Function
REQ-015 in_ready SHALL be a registered-state signal: 1 when the output stage holds fewer than 2 entries and rst is low.
REQ-016 a_ready SHALL be b_valid & in_ready, and b_ready SHALL be a_valid & in_ready.
REQ-017 A join fire SHALL occur when a_valid & b_valid & in_ready, consuming one A and one B word in the same cycle; neither stream advances alone.
REQ-018 The sum SHALL be computed zero-extended to width+1 bits, with no overflow and no truncation.
REQ-019 The output stage SHALL use three states. EMPTY: 0 entries. ONE: main register valid. TWO: main and skid registers valid.
REQ-020 sum_valid SHALL be 1 when state != EMPTY, and sum_data SHALL always present the main register.
REQ-021 A pop SHALL occur when sum_valid & sum_ready.
REQ-022 EMPTY transitions: fire -> ONE, main <= sum.
REQ-023 ONE transitions: fire & pop -> ONE, main <= sum. fire & !pop -> TWO, skid <= sum. !fire & pop -> EMPTY. No fire and no pop -> stay.
REQ-024 TWO transitions: in_ready = 0, so no fire is possible. pop -> ONE, main <= skid. No pop -> stay.
REQ-025 Latency SHALL be 1 cycle from fire to sum_valid, and sustained throughput SHALL be 1 result per cycle while sum_ready = 1.
REQ-026 There SHALL be no combinational path from sum_ready to a_ready or b_ready, nor from inputs to sum_valid or sum_data.
REQ-027 Results SHALL leave in fire order; none SHALL be dropped or duplicated.
REQ-028 sum_data SHALL hold stable while sum_valid & !sum_ready.
REQ-029 sum_count SHALL increment by 1 per pop, modulo 2^16 (0xFFFF -> 0x0000).

Reset
REQ-030 While rst = 1: state <= EMPTY, main and skid <= 0, sum_count <= 0.
REQ-031 While rst = 1: a_ready = b_ready = 0, sum_valid = 0, sum_data = 0.
REQ-032 Reset asserted mid-operation SHALL discard all held results in that cycle.
REQ-033 The first fire SHALL be possible in the first cycle with rst = 0.

Structure
REQ-034 The state enum (EMPTY, ONE, TWO) SHALL be local to the module; no shared package is required.
REQ-035 The output stage SHALL be a sub-module, valid_ready_skid_buffer, parameterised by data width.
REQ-036 The join, adder and sum_count logic SHALL be in the top module.
REQ-037 The block SHALL connect directly to two ff_fifo_wrapped_in_valid_ready instances on its A and B inputs.

Verification
REQ-038 Stream: A = 3, B = 4 both valid, sum_ready = 1 -> next cycle sum_valid = 1, sum_data = 7, then sum_count = 1.
REQ-039 Width/overflow: width = 8, A = 255, B = 255 -> sum_data = 510 (9'h1FE).
REQ-040 Join stall: a_valid = 1, b_valid = 0 for 5 cycles -> a_ready = 0 and no sum_valid; B = 10 arrives with A = 5 -> sum_data = 15 one cycle later.
REQ-041 Back-pressure: pairs (1,1), (2,2), (3,3) offered with sum_ready = 0 -> state TWO, in_ready = 0, third pair held; raise sum_ready -> outputs 2, 4, 6 in order, no loss.
REQ-042 Full throughput: 100 back-to-back pairs with sum_ready = 1 -> 100 results in 101 cycles, sum_count = 100.
REQ-043 Reset: assert rst for one cycle while in state TWO -> next cycle sum_valid = 0, sum_count = 0, a_ready = b_ready = 0 during rst.
REQ-044 Wrap: force 65536 pops -> sum_count returns to 0.
